// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   TAG_READ_MEMORY - tag carried on every line read request/response
//   LINE_BYTES      - bytes per instruction line
//   state_t         - fetch sequencer states
//   fetch_entry_t   - one buffered instruction with its PC
package fetch_pkg;

  localparam int PC_WIDTH   = 64;
  localparam int INST_WIDTH = 32;
  localparam int INST_BYTES = INST_WIDTH / 8;
  localparam int LINE_BYTES = 64;

  localparam logic [12:0] TAG_READ_MEMORY = 13'h0001;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    HALT
  } state_t;

  typedef struct packed {
    logic [INST_WIDTH-1:0] instruction;
    logic [PC_WIDTH-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// inst_fifo: in-order synchronous FIFO of fetch_entry_t.
// Accepts up to two entries per cycle (a before b) and releases one.
//   clk, reset        - clock, synchronous active-high reset
//   push_a, data_a    - first entry to write this cycle
//   push_b, data_b    - second entry (written after a when both are set)
//   pop               - release the head entry
//   head              - current head entry (valid when !empty)
//   full, empty       - occupancy flags
//   free_count        - number of unoccupied entries
module inst_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_a,
  input  fetch_entry_t data_a,
  input  logic         push_b,
  input  fetch_entry_t data_b,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  free_count
);

  fetch_entry_t mem [DEPTH];

  // One extra pointer bit separates full (MSBs differ) from empty (equal).
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr_b;
  logic [AW:0] used;

  // Entry b lands right behind a, or in a's slot when a is not pushed.
  assign wr_ptr_b = wr_ptr + {{AW{1'b0}}, push_a};

  // NOTE: storage has no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr[AW-1:0]]   <= data_a;
    if (push_b) mem[wr_ptr_b[AW-1:0]] <= data_b;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, push_a} + {{AW{1'b0}}, push_b};
      if (pop && !empty) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  assign used       = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign free_count = (AW+1)'(DEPTH) - used;
  assign head       = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the decoder.
// Requests 64-byte lines on the shared bus, splits every 64-bit response beat
// into two 32-bit instructions (low half first) and queues them with their PC.
// Optional build macro FETCH_HALT_ON_ZERO_EN: stop fetching at the first
// all-zero instruction and raise halted once the queue has drained.
//   clk, reset                  - clock, synchronous active-high reset
//   entry                       - start PC, sampled while reset is high
//   bus_reqcyc/reqack/req/reqtag- line request handshake, address and tag
//   bus_respcyc/respack/resp/resptag - response beat handshake, data and tag
//   inst_valid/inst_ready       - decoder handshake
//   instruction, inst_pc        - head instruction and its PC
//   halted                      - fetch stopped (optional feature only)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS_PER_LINE = 8,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BUS_DATA_WIDTH-1:0]   entry,
  output logic                        bus_reqcyc,
  input  logic                        bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0]   bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
  input  logic                        bus_respcyc,
  output logic                        bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic [BUS_DATA_WIDTH/2-1:0] instruction,
  output logic [BUS_DATA_WIDTH-1:0]   inst_pc,
  output logic                        halted
);

  localparam int W          = BUS_DATA_WIDTH;
  localparam int HW         = BUS_DATA_WIDTH / 2;
  localparam int BEAT_W     = $clog2(BEATS_PER_LINE);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;

  // A whole line must fit before it is requested, so pushes never overflow.
  localparam logic [AW:0] REFILL_THRESHOLD = (AW+1)'(2 * BEATS_PER_LINE);

  state_t              state;
  logic [W-1:0]        fetch_pc;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [W-1:0]        line_addr;
  logic [W-1:0]        pc_lo;
  logic [W-1:0]        pc_hi;
  logic [HW-1:0]       word_lo;
  logic [HW-1:0]       word_hi;
  logic                beat_ack;
  logic                last_beat;
  logic                lo_ok;
  logic                hi_ok;
  logic                push_lo;
  logic                push_hi;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [AW:0]         free_count;
  fetch_entry_t        head;

  assign line_addr = fetch_pc & ~W'(LINE_BYTES - 1);
  assign pc_lo     = line_addr + (W'(beat_cnt) * W'(BEAT_BYTES));
  assign pc_hi     = pc_lo + W'(INST_BYTES);
  assign word_lo   = bus_resp[HW-1:0];
  assign word_hi   = bus_resp[W-1:HW];
  assign last_beat = (beat_cnt == BEAT_W'(BEATS_PER_LINE - 1));

  // Beats are consumed in the same cycle they are offered.
  assign beat_ack    = (state == RESP) && bus_respcyc;
  assign bus_respack = beat_ack;
  assign bus_reqtag  = BUS_TAG_WIDTH'(TAG_READ_MEMORY);

  // Slots before the start PC (unaligned entry) are dropped.
  assign lo_ok = (pc_lo >= fetch_pc);
  assign hi_ok = (pc_hi >= fetch_pc);

`ifdef FETCH_HALT_ON_ZERO_EN
  logic zero_seen;
  logic lo_zero;
  logic hi_zero;
  logic zero_hit;

  assign lo_zero  = lo_ok && (word_lo == '0);
  assign hi_zero  = hi_ok && (word_hi == '0);
  // Once a zero word is seen nothing else from the line is queued.
  assign push_lo  = beat_ack && !zero_seen && lo_ok && !lo_zero;
  assign push_hi  = beat_ack && !zero_seen && !lo_zero && hi_ok && !hi_zero;
  assign zero_hit = beat_ack && !zero_seen && (lo_zero || hi_zero);

  tag_check: assert property (@(posedge clk) disable iff (reset)
    beat_ack |-> (bus_resptag == BUS_TAG_WIDTH'(TAG_READ_MEMORY)));
`else
  logic unused_tag;
  assign unused_tag = ^bus_resptag;
  assign push_lo    = beat_ack && lo_ok;
  assign push_hi    = beat_ack && hi_ok;
  assign halted     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= entry;
      beat_cnt   <= '0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
`ifdef FETCH_HALT_ON_ZERO_EN
      zero_seen  <= 1'b0;
      halted     <= 1'b0;
`endif
    end else begin
`ifdef FETCH_HALT_ON_ZERO_EN
      halted <= (state == HALT) && fifo_empty;
`endif
      case (state)
        IDLE: begin
          if (free_count >= REFILL_THRESHOLD) begin
            state      <= REQ;
            bus_reqcyc <= 1'b1;
            bus_req    <= line_addr;
          end
        end
        REQ: begin
          if (bus_reqack) begin
            state      <= RESP;
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            beat_cnt   <= '0;
          end
        end
        RESP: begin
          if (beat_ack) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
`ifdef FETCH_HALT_ON_ZERO_EN
            if (zero_hit) zero_seen <= 1'b1;
`endif
            if (last_beat) begin
              fetch_pc <= line_addr + W'(LINE_BYTES);
`ifdef FETCH_HALT_ON_ZERO_EN
              state    <= (zero_seen || zero_hit) ? HALT : IDLE;
`else
              state    <= IDLE;
`endif
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_pop = inst_valid && inst_ready;

  inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_a     (push_lo),
    .data_a     ('{instruction: word_lo, pc: pc_lo}),
    .push_b     (push_hi),
    .data_b     ('{instruction: word_hi, pc: pc_hi}),
    .pop        (fifo_pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .free_count (free_count)
  );

  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_full && push_lo && !fifo_pop));

  assign inst_valid  = !fifo_empty;
  assign instruction = head.instruction;
  assign inst_pc     = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// A bus model driven from the main sequence serves line requests; a monitor
// records every instruction the decoder accepts and the sequence compares
// that stream against an expected stream built from the request addresses.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        bus_reqcyc;
  logic        bus_reqack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .entry       (entry),
    .bus_reqcyc  (bus_reqcyc),
    .bus_reqack  (bus_reqack),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_respcyc (bus_respcyc),
    .bus_respack (bus_respack),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .instruction (instruction),
    .inst_pc     (inst_pc),
    .halted      (halted)
  );

  int tests = 0;
  int fails = 0;

  fetch_entry_t exp_q[$];
  fetch_entry_t got_q[$];
  logic [63:0]  zero_pc = '1;
  logic         first_valid;
  logic [63:0]  first_pc;

  // Decoder side: record every accepted head, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready)
      got_q.push_back('{instruction: instruction, pc: inst_pc});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory image: two fixed opening words, then a PC-derived pattern.
  function automatic logic [31:0] word_of(input logic [63:0] pc);
    if (pc == zero_pc)       return 32'h0;
    if (pc == 64'h1000)      return 32'h0010_0093;
    if (pc == 64'h1004)      return 32'h0000_0013;
    return {16'hA5C3, pc[15:0]};
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] line, input int k);
    logic [63:0] pc;
    pc = line + 64'(8 * k);
    return {word_of(pc + 64'd4), word_of(pc)};
  endfunction

  // Expected instructions for one line fetched with start PC 'start'.
  task automatic model_line(input logic [63:0] line, input logic [63:0] start);
    bit stop;
    logic [63:0] pc;
    stop = 1'b0;
    for (int s = 0; s < 16; s++) begin
      pc = line + 64'(4 * s);
      if (pc >= start && !stop) begin
`ifdef FETCH_HALT_ON_ZERO_EN
        if (word_of(pc) == 32'h0) stop = 1'b1;
        else exp_q.push_back('{instruction: word_of(pc), pc: pc});
`else
        exp_q.push_back('{instruction: word_of(pc), pc: pc});
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_reset(input logic [63:0] e);
    reset       = 1'b1;
    entry       = e;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    tick();
  endtask

  task automatic end_reset();
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_reqcyc) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Serve one line request: optional delayed grant, optional one-cycle gaps
  // between beats, n_beats beats offered.
  task automatic serve_line(input logic [63:0] exp_addr, input int ack_delay,
                            input bit gap, input int n_beats);
    bit ok;
    int acks;
    int cyc;
    int hold_bad;
    wait_req(200, ok);
    check("req_seen", 64'(ok), 64'd1);
    if (!ok) return;
    check("req_addr", bus_req, exp_addr);
    hold_bad = 0;
    for (int d = 0; d < ack_delay; d++) begin
      tick();
      if (!bus_reqcyc || bus_req !== exp_addr) hold_bad++;
    end
    if (ack_delay > 0) check("req_stable", 64'(hold_bad), 64'd0);
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    acks = 0;
    cyc  = 0;
    while (acks < n_beats && cyc < 100) begin
      if (gap && cyc[0]) begin
        bus_respcyc = 1'b0;
      end else begin
        bus_respcyc = 1'b1;
        bus_resp    = beat_data(exp_addr, acks);
      end
      #1;
      if (bus_respcyc && bus_respack) acks++;
      @(posedge clk);
      #1;
      if (acks == 1 && (cyc == 0 || (gap && cyc == 0))) begin
        first_valid = inst_valid;
        first_pc    = inst_pc;
      end
      cyc++;
    end
    bus_respcyc = 1'b0;
    check("beat_acks", 64'(acks), 64'(n_beats));
    if (n_beats == 8) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      check("no_extra_ack", 64'(bus_respack), 64'd0);
      bus_respcyc = 1'b0;
    end
  endtask

  task automatic compare_stream(input string tag);
    int mism;
    int n;
    mism = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_order"}, 64'(mism), 64'd0);
  endtask

  initial begin
    bit ok;
    int req_bad;
    reset       = 1'b1;
    entry       = '0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = 13'h0001;
    inst_ready  = 1'b1;
    first_valid = 1'b0;
    first_pc    = '0;

    // 1: aligned entry, decoder always ready.
    begin_reset(64'h1000);
    tick();
    check("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check("rst_req", bus_req, 64'd0);
    check("rst_respack", 64'(bus_respack), 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("reqtag", 64'(bus_reqtag), 64'h0001);
    end_reset();
    model_line(64'h1000, 64'h1000);
    serve_line(64'h1000, 0, 1'b0, 8);
    check("first_latency_valid", 64'(first_valid), 64'd1);
    check("first_latency_pc", first_pc, 64'h1000);
    drain(30);
    compare_stream("t1");
    if (got_q.size() > 1) begin
      check("t1_inst0", 64'(got_q[0].instruction), 64'h0010_0093);
      check("t1_inst1", 64'(got_q[1].instruction), 64'h0000_0013);
      check("t1_pc1", got_q[1].pc, 64'h1004);
    end
    wait_req(50, ok);
    check("t1_next_req_seen", 64'(ok), 64'd1);
    check("t1_next_req", bus_req, 64'h1040);

    // 2: unaligned entry, only the tail of the first line is queued.
    begin_reset(64'h1034);
    end_reset();
    model_line(64'h1000, 64'h1034);
    serve_line(64'h1000, 0, 1'b0, 8);
    drain(20);
    compare_stream("t2");
    if (got_q.size() > 0) check("t2_first_pc", got_q[0].pc, 64'h1034);

    // 3: decoder stalled until the queue is full, then released.
    inst_ready = 1'b0;
    begin_reset(64'h1000);
    end_reset();
    model_line(64'h1000, 64'h1000);
    serve_line(64'h1000, 0, 1'b0, 8);
    model_line(64'h1040, 64'h1040);
    serve_line(64'h1040, 0, 1'b0, 8);
    req_bad = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus_reqcyc) req_bad++;
    end
    check("t3_no_req_when_full", 64'(req_bad), 64'd0);
    check("t3_head_valid", 64'(inst_valid), 64'd1);
    check("t3_head_inst", 64'(instruction), 64'h0010_0093);
    check("t3_head_pc", inst_pc, 64'h1000);
    inst_ready = 1'b1;
    wait_req(100, ok);
    check("t3_resume_req", 64'(ok), 64'd1);
    check("t3_pops_before_req", 64'(got_q.size() >= 16), 64'd1);
    model_line(64'h1080, 64'h1080);
    serve_line(64'h1080, 0, 1'b0, 8);
    drain(60);
    compare_stream("t3");

    // 4: slow grant and gapped response beats.
    begin_reset(64'h3000);
    end_reset();
    model_line(64'h3000, 64'h3000);
    serve_line(64'h3000, 5, 1'b1, 8);
    drain(30);
    compare_stream("t4");

    // 5: a zero instruction in the line.
    zero_pc = 64'h1010;
    begin_reset(64'h1000);
    end_reset();
    model_line(64'h1000, 64'h1000);
    serve_line(64'h1000, 0, 1'b0, 8);
    drain(30);
    compare_stream("t5");
`ifdef FETCH_HALT_ON_ZERO_EN
    check("t5_halted", 64'(halted), 64'd1);
    req_bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_reqcyc) req_bad++;
    end
    check("t5_no_req_after_halt", 64'(req_bad), 64'd0);
`else
    check("t5_not_halted", 64'(halted), 64'd0);
    wait_req(50, ok);
    check("t5_next_req", bus_req, 64'h1040);
`endif
    zero_pc = '1;

    // 6: reset in the middle of a line.
    begin_reset(64'h1000);
    end_reset();
    serve_line(64'h1000, 0, 1'b0, 4);
    reset = 1'b1;
    entry = 64'h2000;
    tick();
    check("t6_rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    check("t6_rst_req", bus_req, 64'd0);
    check("t6_rst_valid", 64'(inst_valid), 64'd0);
    bus_respcyc = 1'b1;
    #1;
    check("t6_rst_respack", 64'(bus_respack), 64'd0);
    bus_respcyc = 1'b0;
    end_reset();
    model_line(64'h2000, 64'h2000);
    serve_line(64'h2000, 0, 1'b0, 8);
    drain(30);
    compare_stream("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction decoder.
- Reads 64-byte instruction lines over the shared request/response bus.
- Splits each 64-bit response beat into two 32-bit instructions and buffers them in an in-order FIFO.
- Presents one instruction and its PC per cycle to the decoder on a valid/ready handshake.

Parameters:
- BUS_DATA_WIDTH, 64, bus data width and PC width.
- BUS_TAG_WIDTH, 13, width of the request/response tag.
- BEATS_PER_LINE, 8, response beats per line request (64 bytes).
- FIFO_DEPTH, 32, instruction FIFO entries; power of two, ≥ 2*BEATS_PER_LINE.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- entry  in  BUS_DATA_WIDTH  initial PC, sampled in the cycle reset is high.
- bus_reqcyc  out  1  request valid.
- bus_reqack  in  1  request accepted.
- bus_req  out  BUS_DATA_WIDTH  line-aligned request address.
- bus_reqtag  out  BUS_TAG_WIDTH  request tag, constant TAG_READ_MEMORY.
- bus_respcyc  in  1  response beat valid.
- bus_respack  out  1  response beat consumed.
- bus_resp  in  BUS_DATA_WIDTH  response data.
- bus_resptag  in  BUS_TAG_WIDTH  response tag (checked only under the optional feature).
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decoder accepts the head this cycle.
- instruction  out  BUS_DATA_WIDTH/2  head instruction word.
- inst_pc  out  BUS_DATA_WIDTH  PC of the head instruction.
- halted  out  1  fetch stopped (optional feature only).

Behaviour:
- Reset (synchronous, active-high): state=IDLE; fetch_pc=entry; FIFO emptied; beat counter 0.
  - Outputs during and after reset: bus_reqcyc=0, bus_req=0, bus_respack=0, inst_valid=0, halted=0.
- Reset mid-transfer abandons the line immediately. The bus environment is reset with the block; no stale beats are expected afterwards.
- State machine:
  - IDLE: go to REQ when FIFO free entries ≥ 2*BEATS_PER_LINE.
  - REQ: bus_reqcyc=1 and bus_req={fetch_pc[63:6],6'b0}, both held stable until bus_reqack. On bus_reqack go to RESP and clear the beat counter.
  - RESP: bus_respack = bus_respcyc, combinationally. Each acked beat increments the counter. The beat at offset k covers PCs line+8k (bits 31:0) and line+8k+4 (bits 63:32).
  - Line complete: after BEATS_PER_LINE beats, fetch_pc = line+64 and state returns to IDLE (next REQ no earlier than the following cycle).
- Entry alignment:
  - Only instructions with PC ≥ fetch_pc are pushed; earlier slots in the first line are discarded.
  - Entry need not be 64-byte aligned; it must be 4-byte aligned.
- Push per beat: 0, 1 or 2 instructions, low half first. The admission rule guarantees the FIFO never overflows.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits; full/empty are distinguished by the MSB.
  - Simultaneous push and pop in the same cycle are both honoured.
  - Head is popped when inst_valid && inst_ready.
  - instruction and inst_pc are driven from the head register and stay stable while inst_valid=1 and inst_ready=0.
- Latency: first instruction is visible at inst_valid 1 cycle after the beat that carries it is acked.
- Pointer and PC arithmetic wraps modulo 2^width.

Optional Feature:
- Macro: FETCH_HALT_ON_ZERO_EN.
- With the macro defined:
  - An all-zero instruction (PC ≥ fetch_pc) is not pushed; instructions after it in the line are discarded.
  - Remaining beats of the line are still acked; then state = HALT.
  - HALT is left only by reset. halted=1 once HALT is reached and the FIFO has drained.
  - bus_resptag ≠ TAG_READ_MEMORY during RESP fires an assertion.
- Without the macro: zero words are pushed like any other instruction, fetch continues indefinitely, halted is tied to 0, and there is no tag check.

Decomposition:
- Shared package fetch_pkg:
  - TAG_READ_MEMORY constant.
  - LINE_BYTES=64.
  - State enum {IDLE, REQ, RESP, HALT}.
  - Struct fetch_entry_t {instruction, pc}.
- One sub-module: inst_fifo, a parameterised synchronous FIFO of fetch_entry_t with push/pop/full/empty/free_count.

Test Plan:
- entry=0x1000, decoder always ready, line beats 0x00000013_00100093 ... → 16 instructions pop in order; first instruction=0x00100093 @pc 0x1000, second 0x00000013 @0x1004; next bus_req=0x1040.
- entry=0x1034 → bus_req=0x1000; only beats 6–7 (PCs 0x1034..0x103C) are pushed, 3 instructions in total; first inst_pc=0x1034.
- inst_ready held 0 for 100 cycles → FIFO reaches 32, no further REQ is issued, head is stable; releasing ready resumes fetch once free entries ≥ 16.
- bus_reqack delayed 5 cycles, bus_respcyc gapped every other cycle → bus_req stable throughout, 8 acks exactly, no lost or duplicated instructions.
- FETCH_HALT_ON_ZERO_EN defined, zero word at 0x1010 → PCs 0x1000–0x100C delivered, remaining beats acked, halted=1 after drain, bus_reqcyc stays 0.
- reset asserted in RESP after beat 3, entry=0x2000 → outputs at reset values next cycle; next bus_req=0x2000.
